// File: rtl/time_syn_pkg.sv
// Shared constants for the time-sync frame transmitter: type codes, beat
// indices, slot indices and the TX FSM state encoding.
package time_syn_pkg;

    localparam int unsigned AXIS_W = 64;
    localparam int unsigned SEQ_W  = 8;

    localparam logic [7:0] CODE_TS  = 8'h66;
    localparam logic [7:0] CODE_STD = 8'h88;
    localparam logic [7:0] CODE_RET = 8'h55;

    localparam int unsigned BEAT_HDR = 0;
    localparam int unsigned BEAT_TS  = 1;

    localparam int unsigned SLOT_TS  = 0;
    localparam int unsigned SLOT_STD = 1;
    localparam int unsigned SLOT_RET = 2;
    localparam int unsigned N_SLOT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_TSB  = 2'd2,
        ST_PAD  = 2'd3
    } tx_state_e;

    function automatic logic [AXIS_W-1:0] hdr_word(input logic [7:0] code,
                                                   input logic [SEQ_W-1:0] seq);
        return {48'h0, seq, code};
    endfunction

endpackage

// File: rtl/time_syn_pending_slot.sv
// One pending-request slot: flag plus latest value. A set on the clear
// cycle re-arms the slot and is not an overrun.
module time_syn_pending_slot #(
    parameter int unsigned P_W = 64
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_set,
    input  logic [P_W-1:0] i_val,
    input  logic           i_clr,
    output logic           o_flag,
    output logic [P_W-1:0] o_val,
    output logic           o_flag_nxt_c,
    output logic           o_overrun_c
);

    logic           r_flag;
    logic [P_W-1:0] r_val;

    assign o_flag_nxt_c = i_set | (r_flag & ~i_clr);
    assign o_overrun_c  = i_set & r_flag & ~i_clr;
    assign o_flag       = r_flag;
    assign o_val        = r_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flag <= 1'b0;
            r_val  <= '0;
        end else begin
            r_flag <= o_flag_nxt_c;
            if (i_set) begin
                r_val <= i_val;
            end
        end
    end

endmodule

// File: rtl/time_syn_tx_arb.sv
// Time-sync frame transmitter: latches TS/STD/RETURN requests in pending
// slots, arbitrates TS > RETURN > STD and streams fixed-length AXIS frames.
module time_syn_tx_arb
    import time_syn_pkg::*;
#(
    parameter int unsigned P_FRAME_LEN = 8,
    parameter int unsigned P_TS_W      = 64,
    parameter int unsigned P_TS_COMP   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_send_ts_valid,
    input  logic [P_TS_W-1:0] i_local_time,
    input  logic              i_send_std_valid,
    input  logic [P_TS_W-1:0] i_std_time,
    input  logic              i_return_valid,
    input  logic [P_TS_W-1:0] i_return_ts,
    input  logic              i_tx_axis_tready,
    output logic              o_tx_axis_tvalid,
    output logic [63:0]       o_tx_axis_tdata,
    output logic              o_tx_axis_tlast,
    output logic [7:0]        o_tx_axis_tkeep,
    output logic              o_tx_axis_tuser,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int unsigned       CNT_W   = $clog2(P_FRAME_LEN);
    localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(P_FRAME_LEN - 1);
    localparam logic [P_TS_W-1:0] LP_COMP = P_TS_W'(P_TS_COMP);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_beat;
    logic [CNT_W-1:0]   w_beat_nxt;
    logic [CNT_W-1:0]   w_beat_inc;
    logic               r_tvalid;
    logic               w_tvalid_nxt;
    logic [AXIS_W-1:0]  r_tdata;
    logic [AXIS_W-1:0]  w_tdata_nxt;
    logic               r_tlast;
    logic               w_tlast_nxt;
    logic [SEQ_W-1:0]   r_seq;
    logic [SEQ_W-1:0]   w_seq_nxt;
    logic [AXIS_W-1:0]  r_ts_word;
    logic [AXIS_W-1:0]  w_ts_word_nxt;
    logic [7:0]         w_code;
    logic               r_overrun;
    logic               r_busy;
    logic               w_hs;

    logic [N_SLOT-1:0]  w_set;
    logic [N_SLOT-1:0]  w_gnt;
    logic [N_SLOT-1:0]  w_flag;
    logic [N_SLOT-1:0]  w_flag_nxt;
    logic [N_SLOT-1:0]  w_ovr;
    logic [P_TS_W-1:0]  w_val_ts;
    logic [P_TS_W-1:0]  w_val_std;
    logic [P_TS_W-1:0]  w_val_ret;
    logic [P_TS_W-1:0]  w_sum_ts;
    logic [P_TS_W-1:0]  w_sum_std;

    assign w_set[SLOT_TS]  = i_send_ts_valid;
    assign w_set[SLOT_STD] = i_send_std_valid;
    assign w_set[SLOT_RET] = i_return_valid;

    time_syn_pending_slot #(.P_W(P_TS_W)) u_slot_ts (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_set(w_set[SLOT_TS]), .i_val(i_local_time), .i_clr(w_gnt[SLOT_TS]),
        .o_flag(w_flag[SLOT_TS]), .o_val(w_val_ts),
        .o_flag_nxt_c(w_flag_nxt[SLOT_TS]), .o_overrun_c(w_ovr[SLOT_TS])
    );

    time_syn_pending_slot #(.P_W(P_TS_W)) u_slot_std (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_set(w_set[SLOT_STD]), .i_val(i_std_time), .i_clr(w_gnt[SLOT_STD]),
        .o_flag(w_flag[SLOT_STD]), .o_val(w_val_std),
        .o_flag_nxt_c(w_flag_nxt[SLOT_STD]), .o_overrun_c(w_ovr[SLOT_STD])
    );

    time_syn_pending_slot #(.P_W(P_TS_W)) u_slot_ret (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_set(w_set[SLOT_RET]), .i_val(i_return_ts), .i_clr(w_gnt[SLOT_RET]),
        .o_flag(w_flag[SLOT_RET]), .o_val(w_val_ret),
        .o_flag_nxt_c(w_flag_nxt[SLOT_RET]), .o_overrun_c(w_ovr[SLOT_RET])
    );

    // Compensation wraps within the timestamp width before zero-extension.
    assign w_sum_ts   = w_val_ts + LP_COMP;
    assign w_sum_std  = w_val_std + LP_COMP;
    assign w_hs       = r_tvalid & i_tx_axis_tready;
    assign w_beat_inc = r_beat + CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_tvalid_nxt  = r_tvalid;
        w_tdata_nxt   = r_tdata;
        w_tlast_nxt   = r_tlast;
        w_seq_nxt     = r_seq;
        w_ts_word_nxt = r_ts_word;
        w_gnt         = '0;
        w_code        = CODE_TS;
        case (r_state)
            ST_IDLE: begin
                if (|w_flag) begin
                    if (w_flag[SLOT_TS]) begin
                        w_gnt[SLOT_TS] = 1'b1;
                        w_code         = CODE_TS;
                        w_ts_word_nxt  = 64'(w_sum_ts);
                    end else if (w_flag[SLOT_RET]) begin
                        w_gnt[SLOT_RET] = 1'b1;
                        w_code          = CODE_RET;
                        w_ts_word_nxt   = 64'(w_val_ret);
                    end else begin
                        w_gnt[SLOT_STD] = 1'b1;
                        w_code          = CODE_STD;
                        w_ts_word_nxt   = 64'(w_sum_std);
                    end
                    w_state_nxt  = ST_HDR;
                    w_beat_nxt   = CNT_W'(BEAT_HDR);
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = hdr_word(w_code, r_seq);
                    w_tlast_nxt  = 1'b0;
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    w_state_nxt = ST_TSB;
                    w_beat_nxt  = CNT_W'(BEAT_TS);
                    w_tdata_nxt = r_ts_word;
                    w_tlast_nxt = (CNT_W'(BEAT_TS) == LP_LAST);
                end
            end
            ST_TSB, ST_PAD: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_state_nxt  = ST_IDLE;
                        w_beat_nxt   = CNT_W'(BEAT_HDR);
                        w_tvalid_nxt = 1'b0;
                        w_tdata_nxt  = '0;
                        w_tlast_nxt  = 1'b0;
                        w_seq_nxt    = r_seq + SEQ_W'(1);
                    end else begin
                        w_state_nxt = ST_PAD;
                        w_beat_nxt  = w_beat_inc;
                        w_tdata_nxt = '0;
                        w_tlast_nxt = (w_beat_inc == LP_LAST);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
            r_seq     <= '0;
            r_ts_word <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_tvalid  <= w_tvalid_nxt;
            r_tdata   <= w_tdata_nxt;
            r_tlast   <= w_tlast_nxt;
            r_seq     <= w_seq_nxt;
            r_ts_word <= w_ts_word_nxt;
            r_overrun <= |w_ovr;
            r_busy    <= (w_state_nxt != ST_IDLE) | (|w_flag_nxt);
        end
    end

    assign o_tx_axis_tvalid = r_tvalid;
    assign o_tx_axis_tdata  = r_tdata;
    assign o_tx_axis_tlast  = r_tlast;
    assign o_tx_axis_tkeep  = 8'hFF;
    assign o_tx_axis_tuser  = 1'b0;
    assign o_overrun        = r_overrun;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_time_syn_tx_arb.sv
// Directed bench for time_syn_tx_arb: default build (8 beats, 64-bit) plus a
// short-frame build (2 beats, 32-bit) sharing clock and reset.
module tb_time_syn_tx_arb;

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [2:0]       req;     // [0] TS, [1] STD, [2] RETURN
        logic [63:0]      t_ts;
        logic [63:0]      t_std;
        logic [63:0]      t_ret;
        int               nfrm;
        logic [2:0][7:0]  code;
        logic [2:0][63:0] word;
        bit               bp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        ts_v, std_v, ret_v, tready;
    logic [63:0] lt, st, rt;
    logic        tvalid, tlast, tuser, ovr, busy;
    logic [63:0] tdata;
    logic [7:0]  tkeep;

    logic        ts2_v, std2_v, ret2_v, tready2;
    logic [31:0] lt2, st2, rt2;
    logic        tvalid2, tlast2, tuser2, ovr2, busy2;
    logic [63:0] tdata2;
    logic [7:0]  tkeep2;

    int          checks;
    int          errs;
    int          cyc;
    int          ovr_cnt;
    int          last_cyc;
    bit          bp_en;
    bit          prev_stall;
    logic [63:0] prev_d;
    logic        prev_l;
    logic [7:0]  seq_exp;
    logic [7:0]  seq2_exp;
    beat_t       q1[$];
    beat_t       q2[$];
    vec_t        vecs[7];

    time_syn_tx_arb dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_send_ts_valid(ts_v), .i_local_time(lt),
        .i_send_std_valid(std_v), .i_std_time(st),
        .i_return_valid(ret_v), .i_return_ts(rt),
        .i_tx_axis_tready(tready),
        .o_tx_axis_tvalid(tvalid), .o_tx_axis_tdata(tdata),
        .o_tx_axis_tlast(tlast), .o_tx_axis_tkeep(tkeep),
        .o_tx_axis_tuser(tuser), .o_overrun(ovr), .o_busy(busy)
    );

    time_syn_tx_arb #(.P_FRAME_LEN(2), .P_TS_W(32), .P_TS_COMP(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_send_ts_valid(ts2_v), .i_local_time(lt2),
        .i_send_std_valid(std2_v), .i_std_time(st2),
        .i_return_valid(ret2_v), .i_return_ts(rt2),
        .i_tx_axis_tready(tready2),
        .o_tx_axis_tvalid(tvalid2), .o_tx_axis_tdata(tdata2),
        .o_tx_axis_tlast(tlast2), .o_tx_axis_tkeep(tkeep2),
        .o_tx_axis_tuser(tuser2), .o_overrun(ovr2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) tready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;

    function automatic logic [63:0] hdr(input logic [7:0] c, input logic [7:0] s);
        return {48'h0, s, c};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Capture handshakes and watch the AXIS hold rules at each active edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(tvalid === 1'b1 && tdata === prev_d && tlast === prev_l)) begin
                    errs++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             tvalid, tdata, tlast, prev_d, prev_l);
                end
            end
            if (tvalid && tready) q1.push_back('{tdata, tlast, cyc});
            if (tvalid2 && tready2) q2.push_back('{tdata2, tlast2, cyc});
            if (ovr) ovr_cnt++;
            prev_stall = tvalid && !tready;
            prev_d     = tdata;
            prev_l     = tlast;
        end
    end

    task automatic wait_q(input int which, input int n, output bit ok);
        int t = 0;
        while (((which == 0) ? q1.size() : q2.size()) < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = (((which == 0) ? q1.size() : q2.size()) >= n);
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL wait_q%0d: got %0d beats expected %0d", which, 
                     (which == 0) ? q1.size() : q2.size(), n);
        end
    endtask

    task automatic pulse(input logic [2:0] req, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        ts_v = req[0]; std_v = req[1]; ret_v = req[2];
        lt = a; st = b; rt = c;
        @(negedge clk);
        ts_v = 1'b0; std_v = 1'b0; ret_v = 1'b0;
    endtask

    task automatic pulse2(input logic [31:0] v);
        @(negedge clk);
        ts2_v = 1'b1; lt2 = v;
        @(negedge clk);
        ts2_v = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] code, input logic [63:0] word, input bit gap);
        bit          ok;
        beat_t       b;
        logic [63:0] ed;
        wait_q(0, 8, ok);
        if (!ok) return;
        for (int i = 0; i < 8; i++) begin
            b  = q1.pop_front();
            ed = (i == 0) ? hdr(code, seq_exp) : (i == 1) ? word : 64'h0;
            chk($sformatf("frame_beat%0d", i), {63'h0, b.l, b.d}, {63'h0, (i == 7), ed});
            if (i == 0 && gap) chk("idle_gap", 128'(b.cyc - last_cyc), 128'(2));
            if (i == 7) last_cyc = b.cyc;
        end
        seq_exp++;
    endtask

    initial begin
        bit    ok;
        beat_t b0, b1;
        int    base;
        logic [31:0] v2;
        logic [63:0] e2;

        vecs[0] = '{3'b001, 64'h100, 64'h0, 64'h0, 1,
                    {8'h00, 8'h00, 8'h66}, {64'h0, 64'h0, 64'h102}, 1'b0};
        vecs[1] = '{3'b111, 64'h10, 64'h20, 64'h30, 3,
                    {8'h88, 8'h55, 8'h66}, {64'h22, 64'h30, 64'h12}, 1'b0};
        vecs[2] = '{3'b100, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1,
                    {8'h00, 8'h00, 8'h55}, {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0};
        vecs[3] = '{3'b010, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1,
                    {8'h00, 8'h00, 8'h88}, {64'h0, 64'h0, 64'h1}, 1'b0};
        vecs[4] = '{3'b011, 64'h1234_5678_9ABC_DEF0, 64'h7, 64'h0, 2,
                    {8'h00, 8'h88, 8'h66}, {64'h0, 64'h9, 64'h1234_5678_9ABC_DEF2}, 1'b0};
        vecs[5] = '{3'b001, 64'h100, 64'h0, 64'h0, 1,
                    {8'h00, 8'h00, 8'h66}, {64'h0, 64'h0, 64'h102}, 1'b1};
        vecs[6] = '{3'b111, 64'h10, 64'h20, 64'h30, 3,
                    {8'h88, 8'h55, 8'h66}, {64'h22, 64'h30, 64'h12}, 1'b1};

        checks = 0; errs = 0; cyc = 0; ovr_cnt = 0; last_cyc = 0;
        seq_exp = 8'd0; seq2_exp = 8'd0; bp_en = 1'b0; prev_stall = 1'b0;
        rst_n = 1'b0; tready = 1'b1; tready2 = 1'b1;
        ts_v = 1'b0; std_v = 1'b0; ret_v = 1'b0; lt = '0; st = '0; rt = '0;
        ts2_v = 1'b0; std2_v = 1'b0; ret2_v = 1'b0; lt2 = '0; st2 = '0; rt2 = '0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {123'h0, tvalid, tlast, tuser, ovr, busy}, 128'h0);
        chk("rst_tdata", {64'h0, tdata}, 128'h0);
        chk("rst_tkeep", {112'h0, tkeep, tkeep2}, {112'h0, 8'hFF, 8'hFF});
        chk("rst_dut2", {60'h0, tvalid2, tuser2, ovr2, busy2, tdata2}, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Request latency: flag after edge k, header valid after edge k+1.
        pulse(3'b001, 64'h55, 64'h0, 64'h0);
        chk("req_flag_only", {126'h0, tvalid, busy}, 128'h1);
        @(negedge clk);
        chk("hdr_latency", {63'h0, tvalid, tdata}, {63'h0, 1'b1, hdr(8'h66, seq_exp)});
        check_frame(8'h66, 64'h57, 1'b0);

        for (int v = 0; v < 7; v++) begin
            repeat (3) @(negedge clk);
            bp_en = vecs[v].bp;
            pulse(vecs[v].req, vecs[v].t_ts, vecs[v].t_std, vecs[v].t_ret);
            for (int f = 0; f < vecs[v].nfrm; f++)
                check_frame(vecs[v].code[f], vecs[v].word[f], (f > 0) && !vecs[v].bp);
            bp_en = 1'b0;
        end

        // Overrun: two STD requests while a TS frame is streaming.
        repeat (3) @(negedge clk);
        base = ovr_cnt;
        pulse(3'b001, 64'h1, 64'h0, 64'h0);
        repeat (2) @(negedge clk);
        pulse(3'b010, 64'h0, 64'h5, 64'h0);
        pulse(3'b010, 64'h0, 64'h9, 64'h0);
        check_frame(8'h66, 64'h3, 1'b0);
        check_frame(8'h88, 64'h0B, 1'b1);
        chk("overrun_count", 128'(ovr_cnt - base), 128'(1));

        // Short frames: 32-bit wrap of the compensated value, then sequence wrap.
        for (int i = 0; i < 257; i++) begin
            v2 = (i == 0) ? 32'hFFFF_FFFF : 32'(i * 3);
            e2 = (i == 0) ? 64'h1 : 64'(v2 + 32'd2);
            pulse2(v2);
            wait_q(1, 2, ok);
            if (!ok) break;
            b0 = q2.pop_front();
            b1 = q2.pop_front();
            chk($sformatf("d2_hdr%0d", i), {63'h0, b0.l, b0.d}, {63'h0, 1'b0, hdr(8'h66, seq2_exp)});
            chk($sformatf("d2_ts%0d", i), {63'h0, b1.l, b1.d}, {63'h0, 1'b1, e2});
            seq2_exp++;
        end
        chk("d2_seq_wrapped", {120'h0, seq2_exp}, {120'h0, 8'd1});

        // Reset during beat 3 with an STD request pending behind the frame.
        repeat (3) @(negedge clk);
        pulse(3'b001, 64'h40, 64'h0, 64'h0);
        pulse(3'b010, 64'h0, 64'h41, 64'h0);
        wait_q(0, 3, ok);
        chk("pre_rst_beat3", {63'h0, tvalid, tdata}, {63'h0, 1'b1, 64'h0});
        #1 rst_n = 1'b0;
        #1 chk("rst_async_drop", {125'h0, tvalid, tlast, busy}, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q1.delete();
        seq_exp = 8'd0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {125'h0, tvalid, busy, ovr}, 128'h0);
        pulse(3'b100, 64'h0, 64'h0, 64'h77);
        check_frame(8'h55, 64'h77, 1'b0);
        repeat (20) @(negedge clk);
        chk("no_stale_frame", {96'h0, 32'(q1.size()), 31'h0, busy}, 128'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
